// File: rtl/bus_cycle_ctrl.sv
// 8085 machine-cycle timing generator: sequences T1/T2/TW/T3[/T4-T6], drives the
// multiplexed AD bus, ALE, RD/WR strobes and status, and inserts READY wait states.
module bus_cycle_ctrl #(
   parameter int WAIT_LIMIT = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [2:0]  cycle_type,
   input  logic        long_fetch,
   input  logic [15:0] addr_in,
   input  logic [7:0]  wdata,
   input  logic [7:0]  ad_in,
   input  logic        ready,
   output logic [7:0]  a_hi,
   output logic [7:0]  ad_out,
   output logic        ad_oe,
   output logic        ale,
   output logic        rd_n,
   output logic        wr_n,
   output logic        io_m,
   output logic        s1,
   output logic        s0,
   output logic        ir_load,
   output logic [7:0]  rdata,
   output logic        busy,
   output logic        done,
   output logic        timeout,
   output logic [2:0]  t_state
);

   localparam logic [2:0] IDLE = 3'd0;
   localparam logic [2:0] T1   = 3'd1;
   localparam logic [2:0] T2   = 3'd2;
   localparam logic [2:0] TW   = 3'd3;
   localparam logic [2:0] T3   = 3'd4;
   localparam logic [2:0] T4   = 3'd5;
   localparam logic [2:0] T5   = 3'd6;
   localparam logic [2:0] T6   = 3'd7;

   localparam logic [2:0] CT_FETCH = 3'd0;
   localparam logic [2:0] CT_MRD   = 3'd1;
   localparam logic [2:0] CT_MWR   = 3'd2;
   localparam logic [2:0] CT_IORD  = 3'd3;
   localparam logic [2:0] CT_IOWR  = 3'd4;
   localparam logic [2:0] CT_INTA  = 3'd5;

   localparam logic [15:0] LIMIT_M1 = (WAIT_LIMIT > 0) ? 16'(WAIT_LIMIT - 1) : 16'd0;

   logic [2:0]  state;
   logic [2:0]  state_next;
   logic [2:0]  type_q;
   logic        long_q;
   logic [7:0]  wdata_q;
   logic [15:0] wait_cnt;
   logic [2:0]  status_new;
   logic        accept;
   logic        is_write;
   logic        is_fetch;
   logic        new_is_io;
   logic        strobe_phase;
   logic        limit_hit;

   assign accept       = (state == IDLE) && start && (cycle_type <= CT_INTA);
   assign is_write     = (type_q == CT_MWR) || (type_q == CT_IOWR);
   assign is_fetch     = (type_q == CT_FETCH) || (type_q == CT_INTA);
   assign new_is_io    = (cycle_type == CT_IORD) || (cycle_type == CT_IOWR);
   assign strobe_phase = (state == T2) || (state == TW) || (state == T3);
   assign limit_hit    = (WAIT_LIMIT != 0) && (wait_cnt == LIMIT_M1) && !ready;

   always_comb begin
      status_new = 3'b000;
      case (cycle_type)
         CT_FETCH: status_new = 3'b011;
         CT_MRD:   status_new = 3'b010;
         CT_MWR:   status_new = 3'b001;
         CT_IORD:  status_new = 3'b110;
         CT_IOWR:  status_new = 3'b101;
         CT_INTA:  status_new = 3'b111;
         default:  status_new = 3'b000;
      endcase
   end

   // Strobes decode straight from state, so a synchronous reset releases them on the same edge
   assign ale     = (state == T1);
   assign ad_oe   = (state == T1) || (strobe_phase && is_write);
   assign rd_n    = !(strobe_phase && !is_write);
   assign wr_n    = !(strobe_phase && is_write);
   assign ir_load = (state == T3) && is_fetch;
   assign busy    = (state != IDLE);
   assign timeout = (state == TW) && limit_hit;
   assign done    = ((state == T3) && !is_fetch) || ((state == T4) && !long_q) || (state == T6);
   assign t_state = state;

   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (accept) state_next = T1;
         T1:   state_next = T2;
         T2:   state_next = ready ? T3 : TW;
         TW:   if (ready || limit_hit) state_next = T3;
         T3:   state_next = is_fetch ? T4 : IDLE;
         T4:   state_next = long_q ? T5 : IDLE;
         T5:   state_next = T6;
         T6:   state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Address and status are registered at acceptance so they are already valid in T1
   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= IDLE;
         type_q   <= CT_FETCH;
         long_q   <= 1'b0;
         wdata_q  <= 8'h00;
         wait_cnt <= 16'd0;
         a_hi     <= 8'h00;
         ad_out   <= 8'h00;
         rdata    <= 8'h00;
         io_m     <= 1'b0;
         s1       <= 1'b0;
         s0       <= 1'b0;
      end else begin
         state <= state_next;
         if (accept) begin
            type_q         <= cycle_type;
            long_q         <= long_fetch;
            wdata_q        <= wdata;
            wait_cnt       <= 16'd0;
            a_hi           <= new_is_io ? addr_in[7:0] : addr_in[15:8];
            ad_out         <= addr_in[7:0];
            {io_m, s1, s0} <= status_new;
         end
         if ((state == T1) && is_write)
            ad_out <= wdata_q;
         if (state == TW)
            wait_cnt <= wait_cnt + 16'd1;
         if ((state == T3) && !is_write)
            rdata <= ad_in;
      end
   end

endmodule

// File: tb/tb_bus_cycle_ctrl.sv
// Directed bench for bus_cycle_ctrl: one unlimited-wait instance and one with WAIT_LIMIT=2.
module tb_bus_cycle_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        start_l;
   logic [2:0]  cycle_type;
   logic        long_fetch;
   logic [15:0] addr_in;
   logic [7:0]  wdata;
   logic [7:0]  ad_in;
   logic        ready;

   logic [7:0]  a_hi, ad_out, rdata;
   logic        ad_oe, ale, rd_n, wr_n, io_m, s1, s0, ir_load, busy, done, timeout;
   logic [2:0]  t_state;

   logic [7:0]  a_hi_l, ad_out_l, rdata_l;
   logic        ad_oe_l, ale_l, rd_n_l, wr_n_l, io_m_l, s1_l, s0_l, ir_load_l, busy_l, done_l, timeout_l;
   logic [2:0]  t_state_l;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   bus_cycle_ctrl #(.WAIT_LIMIT(0)) dut (
      .clk(clk), .rst(rst), .start(start), .cycle_type(cycle_type), .long_fetch(long_fetch),
      .addr_in(addr_in), .wdata(wdata), .ad_in(ad_in), .ready(ready),
      .a_hi(a_hi), .ad_out(ad_out), .ad_oe(ad_oe), .ale(ale), .rd_n(rd_n), .wr_n(wr_n),
      .io_m(io_m), .s1(s1), .s0(s0), .ir_load(ir_load), .rdata(rdata), .busy(busy),
      .done(done), .timeout(timeout), .t_state(t_state)
   );

   bus_cycle_ctrl #(.WAIT_LIMIT(2)) dut_l (
      .clk(clk), .rst(rst), .start(start_l), .cycle_type(cycle_type), .long_fetch(long_fetch),
      .addr_in(addr_in), .wdata(wdata), .ad_in(ad_in), .ready(ready),
      .a_hi(a_hi_l), .ad_out(ad_out_l), .ad_oe(ad_oe_l), .ale(ale_l), .rd_n(rd_n_l), .wr_n(wr_n_l),
      .io_m(io_m_l), .s1(s1_l), .s0(s0_l), .ir_load(ir_load_l), .rdata(rdata_l), .busy(busy_l),
      .done(done_l), .timeout(timeout_l), .t_state(t_state_l)
   );

   task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic st, input logic [2:0] ct, input logic lf,
                                input logic [15:0] addr, input logic [7:0] wd);
      start      = st;
      cycle_type = ct;
      long_fetch = lf;
      addr_in    = addr;
      wdata      = wd;
   endtask

   // Inputs change and outputs are sampled 1 time unit after each rising edge
   task automatic stepClock();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b0; start = 1'b0; start_l = 1'b0; cycle_type = 3'd0; long_fetch = 1'b0;
      addr_in = 16'h0; wdata = 8'h0; ad_in = 8'h0; ready = 1'b1;
      stepClock();
      stepClock();
      checkOutput("rst_tstate", 16'(t_state), 16'd0);
      checkOutput("rst_strobes", {12'd0, ale, rd_n, wr_n, ad_oe}, 16'b0110);
      checkOutput("rst_regs", {a_hi, rdata}, 16'h0000);
      checkOutput("rst_misc", {9'd0, io_m, s1, s0, ir_load, done, timeout, busy}, 16'd0);
      rst = 1'b1;
      stepClock();

      // opcode fetch 0x1234
      applyStimulus(1'b1, 3'd0, 1'b0, 16'h1234, 8'h00);
      ad_in = 8'h43; ready = 1'b1;
      stepClock();
      start = 1'b0;
      checkOutput("f_t1_state", 16'(t_state), 16'd1);
      checkOutput("f_t1_bus", {ad_out, a_hi}, 16'h3412);
      checkOutput("f_t1_sig", {11'd0, ale, ad_oe, rd_n, busy, done}, 16'b11110);
      checkOutput("f_status", {13'd0, io_m, s1, s0}, 16'b011);
      stepClock();
      checkOutput("f_t2_state", 16'(t_state), 16'd2);
      checkOutput("f_t2_sig", {13'd0, ale, rd_n, ad_oe}, 16'b000);
      stepClock();
      checkOutput("f_t3_state", 16'(t_state), 16'd4);
      checkOutput("f_t3_sig", {13'd0, rd_n, ir_load, done}, 16'b010);
      stepClock();
      checkOutput("f_t4_state", 16'(t_state), 16'd5);
      checkOutput("f_t4_sig", {13'd0, rd_n, ir_load, done}, 16'b101);
      checkOutput("f_rdata", 16'(rdata), 16'h43);
      stepClock();
      checkOutput("f_idle", {12'd0, t_state, busy}, 16'd0);
      checkOutput("f_ahi_hold", 16'(a_hi), 16'h12);

      // memory write 0xABCD <- 0x5A
      applyStimulus(1'b1, 3'd2, 1'b0, 16'hABCD, 8'h5A);
      stepClock();
      start = 1'b0;
      checkOutput("w_t1_bus", {ad_out, a_hi}, 16'hCDAB);
      checkOutput("w_status", {13'd0, io_m, s1, s0}, 16'b001);
      stepClock();
      checkOutput("w_t2_sig", {12'd0, wr_n, rd_n, ad_oe, ale}, 16'b0110);
      checkOutput("w_t2_data", 16'(ad_out), 16'h5A);
      stepClock();
      checkOutput("w_t3_sig", {12'd0, t_state, done} , {12'd0, 3'd4, 1'b1});
      checkOutput("w_t3_bus", {7'd0, wr_n, ad_oe, ad_out[6:0]}, {7'd0, 1'b0, 1'b1, 7'h5A});
      stepClock();
      checkOutput("w_idle", {12'd0, wr_n, ad_oe, done, busy}, 16'b1000);

      // memory read with three wait states
      applyStimulus(1'b1, 3'd1, 1'b0, 16'h2000, 8'h00);
      ready = 1'b0;
      stepClock();
      start = 1'b0;
      stepClock();
      stepClock();
      checkOutput("r_tw1", {12'd0, t_state, rd_n}, {12'd0, 3'd3, 1'b0});
      stepClock();
      checkOutput("r_tw2", {12'd0, t_state, rd_n}, {12'd0, 3'd3, 1'b0});
      stepClock();
      checkOutput("r_tw3", {12'd0, t_state, rd_n}, {12'd0, 3'd3, 1'b0});
      ready = 1'b1; ad_in = 8'h9C;
      stepClock();
      checkOutput("r_t3", {12'd0, t_state, done}, {12'd0, 3'd4, 1'b1});
      stepClock();
      checkOutput("r_rdata", 16'(rdata), 16'h9C);
      checkOutput("r_idle", {12'd0, t_state, done}, 16'd0);

      // io read from port 0x77, then back-to-back long fetch
      applyStimulus(1'b1, 3'd3, 1'b0, 16'h0077, 8'h00);
      ad_in = 8'hE1;
      stepClock();
      start = 1'b0;
      checkOutput("io_ahi", 16'(a_hi), 16'h77);
      checkOutput("io_status", {13'd0, io_m, s1, s0}, 16'b110);
      stepClock();
      stepClock();
      checkOutput("io_t3_done", {12'd0, t_state, done}, {12'd0, 3'd4, 1'b1});
      stepClock();
      applyStimulus(1'b1, 3'd0, 1'b1, 16'h4455, 8'h00);
      checkOutput("io_rdata", 16'(rdata), 16'hE1);
      stepClock();
      start = 1'b0;
      checkOutput("lf_t1", {12'd0, t_state, busy}, {12'd0, 3'd1, 1'b1});
      checkOutput("lf_bus", {a_hi, 5'd0, io_m, s1, s0}, {8'h44, 8'h03});
      stepClock();
      stepClock();
      checkOutput("lf_t3", {12'd0, t_state, ir_load}, {12'd0, 3'd4, 1'b1});
      stepClock();
      checkOutput("lf_t4", {12'd0, t_state, done}, {12'd0, 3'd5, 1'b0});
      stepClock();
      checkOutput("lf_t5", {12'd0, t_state, done}, {12'd0, 3'd6, 1'b0});
      stepClock();
      checkOutput("lf_t6", {12'd0, t_state, done}, {12'd0, 3'd7, 1'b1});
      stepClock();
      checkOutput("lf_idle", {12'd0, t_state, busy}, 16'd0);

      // WAIT_LIMIT=2 instance with READY stuck low
      applyStimulus(1'b0, 3'd1, 1'b0, 16'h3000, 8'h00);
      start_l = 1'b1; ready = 1'b0;
      stepClock();
      start_l = 1'b0;
      checkOutput("tl_t1", 16'(t_state_l), 16'd1);
      stepClock();
      start_l = 1'b1;
      stepClock();
      start_l = 1'b0;
      checkOutput("tl_tw1", {12'd0, t_state_l, timeout_l}, {12'd0, 3'd3, 1'b0});
      stepClock();
      checkOutput("tl_tw2", {12'd0, t_state_l, timeout_l}, {12'd0, 3'd3, 1'b1});
      stepClock();
      checkOutput("tl_t3", {11'd0, t_state_l, timeout_l, done_l}, {11'd0, 3'd4, 1'b0, 1'b1});
      stepClock();
      checkOutput("tl_idle", {12'd0, t_state_l, busy_l}, 16'd0);
      stepClock();
      checkOutput("tl_busy_start_ignored", 16'(t_state_l), 16'd0);
      applyStimulus(1'b0, 3'b110, 1'b0, 16'h3000, 8'h00);
      start_l = 1'b1;
      stepClock();
      start_l = 1'b0;
      checkOutput("tl_invalid_ignored", {12'd0, t_state_l, busy_l}, 16'd0);
      checkOutput("main_untouched", {12'd0, t_state, busy}, 16'd0);

      // reset during TW aborts the cycle
      applyStimulus(1'b1, 3'd1, 1'b0, 16'h5000, 8'h00);
      ready = 1'b0;
      stepClock();
      start = 1'b0;
      stepClock();
      stepClock();
      checkOutput("ab_tw", {12'd0, t_state, rd_n}, {12'd0, 3'd3, 1'b0});
      rst = 1'b0;
      stepClock();
      checkOutput("ab_state", {12'd0, t_state, busy}, 16'd0);
      checkOutput("ab_sig", {13'd0, rd_n, ad_oe, done}, 16'b100);
      rst = 1'b1; ready = 1'b1;
      applyStimulus(1'b1, 3'd2, 1'b0, 16'h0102, 8'h77);
      stepClock();
      start = 1'b0;
      checkOutput("ab_new_t1", {a_hi, ad_out}, 16'h0102);
      stepClock();
      checkOutput("ab_new_t2", {7'd0, wr_n, ad_out}, {7'd0, 1'b0, 8'h77});
      stepClock();
      checkOutput("ab_new_t3", {12'd0, t_state, done}, {12'd0, 3'd4, 1'b1});
      stepClock();
      checkOutput("ab_new_idle", {12'd0, t_state, done}, 16'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
